// File: rtl/ws2812b_in_module.sv
// WS2812B receive decoder: classifies high-pulse widths into bits, assembles
// 24-bit GRB words MSB-first, and reports latch, overflow and line faults.
module ws2812b_in_module #(
  parameter int CYCLES_THRESHOLD = 5,
  parameter int CYCLES_RET       = 400,
  parameter int CYCLES_MAXHIGH   = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws2812b_din,
  output logic [23:0] bitstream,
  output logic        bitstream_available,
  input  logic        bitstream_read,
  output logic        frame_end,
  output logic [9:0]  pixel_count,
  output logic        overflow,
  output logic        line_error
);

  localparam logic [15:0] THR16  = 16'(CYCLES_THRESHOLD);
  localparam logic [15:0] RET16  = 16'(CYCLES_RET);
  localparam logic [15:0] MAXH16 = 16'(CYCLES_MAXHIGH);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERROR} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  state_t      state_q, state_d;
  logic        din_meta_q, din_meta_d;
  logic        din_s_q, din_s_d;
  logic        din_prev_q, din_prev_d;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic [15:0] low_cnt_q, low_cnt_d;
  logic [22:0] shift_q, shift_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [23:0] bits_q, bits_d;
  logic        avail_q, avail_d;
  logic        fe_q, fe_d;
  logic [9:0]  pc_q, pc_d;
  logic        ovf_q, ovf_d;
  logic        lerr_q, lerr_d;

  logic rise, fall, new_bit, word_done;

  always_comb begin
    din_meta_d = ws2812b_din;
    din_s_d    = din_meta_q;
    din_prev_d = din_s_q;
    rise       = din_s_q & ~din_prev_q;
    fall       = ~din_s_q & din_prev_q;

    // Each counter restarts at 1 on the edge that begins its level.
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    if (din_s_q) high_cnt_d = rise ? 16'd1 : sat_inc16(high_cnt_q);
    else         low_cnt_d  = fall ? 16'd1 : sat_inc16(low_cnt_q);

    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    bits_d    = bits_q;
    avail_d   = avail_q;
    fe_d      = 1'b0;
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    lerr_d    = lerr_q;
    new_bit   = 1'b0;
    word_done = 1'b0;

    if (avail_q && bitstream_read) avail_d = 1'b0;

    case (state_q)
      IDLE: if (din_s_q) state_d = HIGH;
      HIGH: begin
        if (!din_s_q) begin
          new_bit = (high_cnt_q >= THR16);
          shift_d = {shift_q[21:0], new_bit};
          state_d = LOW;
          if (bit_idx_q == 5'd23) begin
            word_done = 1'b1;
            bit_idx_d = 5'd0;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end else if (high_cnt_d >= MAXH16) begin
          lerr_d    = 1'b1;
          shift_d   = '0;
          bit_idx_d = 5'd0;
          state_d   = ERROR;
        end
      end
      LOW: begin
        if (din_s_q) begin
          state_d = HIGH;
        end else if (low_cnt_d == RET16) begin
          fe_d    = 1'b1;
          pc_d    = '0;
          state_d = IDLE;
          if (bit_idx_q != 5'd0) begin
            lerr_d    = 1'b1;
            bit_idx_d = 5'd0;
          end
        end
      end
      ERROR: begin
        // Pulses are ignored; only a full latch-length low recovers.
        if (!din_s_q && low_cnt_d == RET16) begin
          fe_d    = 1'b1;
          pc_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (!avail_q || bitstream_read) begin
        bits_d  = {shift_q, new_bit};
        avail_d = 1'b1;
        pc_d    = sat_inc10(pc_q);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      bits_q     <= '0;
      avail_q    <= 1'b0;
      fe_q       <= 1'b0;
      pc_q       <= '0;
      ovf_q      <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_meta_q <= din_meta_d;
      din_s_q    <= din_s_d;
      din_prev_q <= din_prev_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      bits_q     <= bits_d;
      avail_q    <= avail_d;
      fe_q       <= fe_d;
      pc_q       <= pc_d;
      ovf_q      <= ovf_d;
      lerr_q     <= lerr_d;
    end
  end

  assign bitstream           = bits_q;
  assign bitstream_available = avail_q;
  assign frame_end           = fe_q;
  assign pixel_count         = pc_q;
  assign overflow            = ovf_q;
  assign line_error          = lerr_q;

endmodule

// File: tb/tb_ws2812b_in_module.sv
// Directed and randomized bench for the WS2812B receive decoder, checked
// against a word-level model of the receiver's buffer and status flags.
module tb_ws2812b_in_module;

  localparam int RET = 400;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws2812b_din;
  logic        bitstream_read;
  logic [23:0] bitstream;
  logic        bitstream_available;
  logic        frame_end;
  logic [9:0]  pixel_count;
  logic        overflow;
  logic        line_error;

  ws2812b_in_module dut (
    .clk                 (clk),
    .resetn              (resetn),
    .ws2812b_din         (ws2812b_din),
    .bitstream           (bitstream),
    .bitstream_available (bitstream_available),
    .bitstream_read      (bitstream_read),
    .frame_end           (frame_end),
    .pixel_count         (pixel_count),
    .overflow            (overflow),
    .line_error          (line_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;
  int fall_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_end === 1'b1) begin
    fe_cnt <= fe_cnt + 1;
    fe_cyc <= cyc;
  end

  // Word-level reference state
  logic [23:0] m_bits;
  bit          m_av, m_ovf, m_lerr;
  int          m_pc, m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_bits"},  32'(bitstream),           32'(m_bits));
    check({tag, "_avail"}, 32'(bitstream_available), 32'(m_av));
    check({tag, "_pc"},    32'(pixel_count),         32'(m_pc));
    check({tag, "_ovf"},   32'(overflow),            32'(m_ovf));
    check({tag, "_lerr"},  32'(line_error),          32'(m_lerr));
    check({tag, "_fe"},    32'(fe_cnt),              32'(m_fe));
  endtask

  task automatic model_reset();
    m_bits = '0; m_av = 0; m_ovf = 0; m_lerr = 0; m_pc = 0;
  endtask

  task automatic model_word(input logic [23:0] w, input bit rd_same);
    if (!m_av || rd_same) begin
      m_bits = w;
      m_av   = 1;
      if (m_pc < 1023) m_pc++;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo, input bit last,
                          input bit chk_lat, input bit rd_end);
    ws2812b_din = 1'b1;
    repeat (hi) @(negedge clk);
    ws2812b_din = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < lo; i++) begin
      if (last && chk_lat && i == 2) check("lat_edge2", 32'(bitstream_available), 32'd0);
      if (last && chk_lat && i == 3) check("lat_edge3", 32'(bitstream_available), 32'd1);
      if (last && rd_end) bitstream_read = (i == 2);
      @(negedge clk);
    end
  endtask

  // Sends the top nbits of w, MSB first; rnd varies widths around the threshold.
  task automatic send_word(input logic [23:0] w, input int nbits, input bit rnd,
                           input bit chk_lat, input bit rd_end);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      int hi, lo, sel;
      b = w[23-i];
      if (rnd) begin
        sel = int'($urandom_range(0, 3));
        if (b) hi = (sel == 0) ? 5 : (sel == 1) ? 39 : int'($urandom_range(6, 38));
        else   hi = (sel == 0) ? 4 : (sel == 1) ? 1 : int'($urandom_range(2, 3));
        lo = (i == 23) ? int'($urandom_range(4, 12)) : int'($urandom_range(2, 12));
      end else begin
        hi = b ? 6 : 4;
        lo = b ? 4 : 6;
      end
      send_bit(b, hi, lo, i == 23, chk_lat, rd_end);
    end
  endtask

  task automatic do_read();
    bitstream_read = 1'b1;
    @(negedge clk);
    bitstream_read = 1'b0;
    m_av = 0;
  endtask

  task automatic latch(input bit partial);
    ws2812b_din = 1'b0;
    repeat (450) @(negedge clk);
    m_fe++;
    m_pc = 0;
    if (partial) m_lerr = 1;
  endtask

  logic [23:0] three [3];

  initial begin
    three[0] = 24'h000000; three[1] = 24'hFFFFFF; three[2] = 24'h123456;
    resetn = 1'b0; ws2812b_din = 1'b0; bitstream_read = 1'b0;
    model_reset();
    m_fe = 0;
    repeat (3) @(negedge clk);
    check_all("reset");
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Single word with exact decode latency, then latch
    send_word(24'hA5C30F, 24, 0, 1, 0);
    model_word(24'hA5C30F, 0);
    check_all("A_word");
    latch(0);
    check_all("A_latch");
    check("A_fe_lat", 32'(fe_cyc), 32'(fall_cyc + RET + 2));
    do_read();
    check_all("A_read");

    // Three words, each read after it arrives
    foreach (three[k]) begin
      send_word(three[k], 24, 0, 0, 0);
      model_word(three[k], 0);
      check_all("B_word");
      do_read();
      check_all("B_read");
    end
    check("B_pc_peak", 32'(pixel_count), 32'd3);
    latch(0);
    check_all("B_latch");

    // Read coinciding with the next word's completion
    send_word(24'h5A5A5A, 24, 0, 0, 0);
    model_word(24'h5A5A5A, 0);
    check_all("D_first");
    send_word(24'hC33C99, 24, 0, 0, 1);
    model_word(24'hC33C99, 1);
    check_all("D_same");
    do_read();
    latch(0);
    check_all("D_latch");

    // Three words never read
    foreach (three[k]) begin
      send_word(three[k], 24, 0, 0, 0);
      model_word(three[k], 0);
      check_all("C_word");
    end
    latch(0);
    check_all("C_latch");
    do_read();

    // Partial word before latch
    send_word(24'hABCDEF, 10, 0, 0, 0);
    latch(1);
    check_all("E_partial");

    // Reset asserted mid-word
    send_word(24'h0F0F0F, 24, 0, 0, 0);
    model_word(24'h0F0F0F, 0);
    send_word(24'hFFFFFF, 7, 0, 0, 0);
    ws2812b_din = 1'b1;
    #3 resetn = 1'b0;
    #1 model_reset();
    check_all("F_reset");
    ws2812b_din = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    send_word(24'h3C5A96, 24, 0, 0, 0);
    model_word(24'h3C5A96, 0);
    check_all("F_after");
    do_read();

    // Stuck-high mid-word, ignored pulses, recovery
    send_word(24'hFFFFFF, 5, 0, 0, 0);
    ws2812b_din = 1'b1;
    repeat (41) @(negedge clk);
    check("G_lerr_pre", 32'(line_error), 32'd0);
    @(negedge clk);
    check("G_lerr_at40", 32'(line_error), 32'd1);
    m_lerr = 1;
    repeat (18) @(negedge clk);
    ws2812b_din = 1'b0;
    repeat (6) @(negedge clk);
    send_word(24'hFFFFFF, 24, 0, 0, 0);
    check_all("G_ignored");
    latch(0);
    check_all("G_latch");
    send_word(24'h00FF00, 24, 0, 0, 0);
    model_word(24'h00FF00, 0);
    check_all("G_clean");
    latch(0);

    // Randomized frames with widths straddling the decision points
    for (int f = 0; f < 5; f++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int j = 0; j < nw; j++) begin
        logic [23:0] w;
        w = 24'($urandom);
        send_word(w, 24, 1, 0, 0);
        model_word(w, 0);
        check_all("R_word");
        if ($urandom_range(0, 1) == 1) begin
          do_read();
          check_all("R_read");
        end
      end
      if (f == 3) begin
        send_word(24'($urandom), int'($urandom_range(1, 23)), 1, 0, 0);
        latch(1);
      end else begin
        latch(0);
      end
      check_all("R_latch");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
